// File: rtl/plab4_net_router_pkg.sv
// Shared ring-router definitions: port indices, one-hot port masks and route encodings.
package plab4_net_router_pkg;

    localparam int NUM_PORTS = 3;
    localparam int PORT_PREV = 0;
    localparam int PORT_TERM = 1;
    localparam int PORT_NEXT = 2;

    localparam logic [2:0] MASK_PREV = 3'b001 << PORT_PREV;
    localparam logic [2:0] MASK_TERM = 3'b001 << PORT_TERM;
    localparam logic [2:0] MASK_NEXT = 3'b001 << PORT_NEXT;

    typedef enum logic [1:0] {
        ROUTE_PREV = 2'd0,
        ROUTE_TERM = 2'd1,
        ROUTE_NEXT = 2'd2,
        ROUTE_NONE = 2'd3
    } route_t;

    // Priority after a grant moves to the port just above the winner, wrapping around.
    function automatic logic [2:0] rotate_prio(input logic [2:0] grants);
        return {grants[1], grants[0], grants[2]};
    endfunction

    // Pick the first requester among three one-hot masks, taken in the given order.
    function automatic logic [2:0] pick3(input logic [2:0] reqs,
                                         input logic [2:0] first,
                                         input logic [2:0] second,
                                         input logic [2:0] third);
        if ((reqs & first) != 3'b000) begin
            return first;
        end else if ((reqs & second) != 3'b000) begin
            return second;
        end else if ((reqs & third) != 3'b000) begin
            return third;
        end else begin
            return 3'b000;
        end
    endfunction

endpackage

// File: rtl/plab4_net_rr_arb3.sv
// Combinational three-way round-robin search: grants the first request at or above the prio bit.
import plab4_net_router_pkg::*;

module plab4_net_rr_arb3 (
    input  logic       en,
    input  logic [2:0] reqs,
    input  logic [2:0] prio,
    output logic [2:0] grants
);

    // Circular search order is selected by the one-hot priority pointer.
    always_comb begin
        grants = 3'b000;
        if (en) begin
            case (prio)
                MASK_TERM: grants = pick3(reqs, MASK_TERM, MASK_NEXT, MASK_PREV);
                MASK_NEXT: grants = pick3(reqs, MASK_NEXT, MASK_PREV, MASK_TERM);
                default:   grants = pick3(reqs, MASK_PREV, MASK_TERM, MASK_NEXT);
            endcase
        end else begin
            grants = 3'b000;
        end
    end

endmodule

// File: rtl/plab4_net_router_output_ctrl.sv
// Ring-router output port control: round-robin grant plus optional downstream credit tracking.
// Credit logic is present only when PLAB4_NET_ROUTER_OUTPUT_CTRL_CREDIT_EN is defined.
import plab4_net_router_pkg::*;

module plab4_net_router_output_ctrl #(
    parameter int p_num_credits    = 3,
    parameter int p_num_free_nbits = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [2:0]                  reqs,
    output logic [2:0]                  grants,
    output logic                        out_val,
    input  logic                        out_rdy,
    input  logic                        credit_return,
    output logic [p_num_free_nbits-1:0] num_free,
    output logic                        credit_err
);

    localparam logic [p_num_free_nbits-1:0] CREDITS_MAX = p_num_free_nbits'(p_num_credits);

    logic [2:0] prio_r;
    logic       arb_en_s;
    logic       xfer_s;

`ifdef PLAB4_NET_ROUTER_OUTPUT_CTRL_CREDIT_EN
    localparam logic [p_num_free_nbits-1:0] CREDIT_ONE  = p_num_free_nbits'(32'd1);
    localparam logic [p_num_free_nbits-1:0] CREDIT_ZERO = p_num_free_nbits'(32'd0);

    logic [p_num_free_nbits-1:0] credits_r;
    logic                        credit_err_r;

    // Reset gates grants directly so a flit offered during reset is never counted as sent.
    assign arb_en_s = reset & out_rdy & (credits_r != CREDIT_ZERO);

    // Credit counter: a send and a return in the same cycle cancel; returns past full are flagged.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            credits_r    <= CREDITS_MAX;
            credit_err_r <= 1'b0;
        end else begin
            case ({xfer_s, credit_return})
                2'b10: begin
                    credits_r    <= credits_r - CREDIT_ONE;
                    credit_err_r <= credit_err_r;
                end
                2'b01: begin
                    if (credits_r == CREDITS_MAX) begin
                        credits_r    <= credits_r;
                        credit_err_r <= 1'b1;
                    end else begin
                        credits_r    <= credits_r + CREDIT_ONE;
                        credit_err_r <= credit_err_r;
                    end
                end
                default: begin
                    credits_r    <= credits_r;
                    credit_err_r <= credit_err_r;
                end
            endcase
        end
    end

    assign num_free   = credits_r;
    assign credit_err = credit_err_r;
`else
    logic unused_credit_return_s;

    assign arb_en_s               = reset & out_rdy;
    assign num_free               = CREDITS_MAX;
    assign credit_err             = 1'b0;
    assign unused_credit_return_s = credit_return;
`endif

    plab4_net_rr_arb3 u_arb (
        .en     (arb_en_s),
        .reqs   (reqs),
        .prio   (prio_r),
        .grants (grants)
    );

    assign out_val = |grants;
    assign xfer_s  = out_val & out_rdy;

    // Priority pointer advances past the winner only on an actual transfer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prio_r <= MASK_PREV;
        end else if (xfer_s) begin
            prio_r <= rotate_prio(grants);
        end else begin
            prio_r <= prio_r;
        end
    end

endmodule

// File: tb/tb_plab4_net_router_output_ctrl.sv
// Self-checking bench for plab4_net_router_output_ctrl: vector table, credit corner cases, random vs model.
module tb_plab4_net_router_output_ctrl;

`ifdef PLAB4_NET_ROUTER_OUTPUT_CTRL_CREDIT_EN
    localparam bit CE = 1'b1;
`else
    localparam bit CE = 1'b0;
`endif
    localparam int NCRED = 3;

    logic       clk;
    logic       reset;
    logic [2:0] reqs;
    logic [2:0] grants;
    logic       out_val;
    logic       out_rdy;
    logic       credit_return;
    logic [1:0] num_free;
    logic       credit_err;

    int tests;
    int fails;

    plab4_net_router_output_ctrl #(
        .p_num_credits    (3),
        .p_num_free_nbits (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .reqs          (reqs),
        .grants        (grants),
        .out_val       (out_val),
        .out_rdy       (out_rdy),
        .credit_return (credit_return),
        .num_free      (num_free),
        .credit_err    (credit_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [2:0] reqs;
        logic       rdy;
        logic       cr;
        logic [2:0] g;
        logic [1:0] nf;
    } vec_t;

    vec_t tbl[16];

    function automatic logic [1:0] nfx(input logic [1:0] x);
        return CE ? x : 2'd3;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive inputs just after the falling edge and let combinational outputs settle.
    task automatic apply(input logic rst, input logic [2:0] r, input logic rdy, input logic cr);
        @(negedge clk);
        reset         = rst;
        reqs          = r;
        out_rdy       = rdy;
        credit_return = cr;
        #2;
    endtask

    task automatic chk_all(input string tag, input logic [2:0] g, input logic [1:0] nf, input logic err);
        chk({tag, "_grants"}, {29'd0, grants}, {29'd0, g});
        chk({tag, "_out_val"}, {31'd0, out_val}, {31'd0, |g});
        chk({tag, "_num_free"}, {30'd0, num_free}, {30'd0, nf});
        chk({tag, "_credit_err"}, {31'd0, credit_err}, {31'd0, err});
    endtask

    int         m_prio;
    int         m_credits;
    logic       m_err;
    int         g_idx;
    int         idx;
    logic [2:0] r_s;
    logic       rdy_s;
    logic       cr_s;
    logic       rst_s;
    logic [2:0] exp_g;

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b0;
        reqs = 3'b000;
        out_rdy = 1'b0;
        credit_return = 1'b0;

        tbl[0]  = '{3'b111, 1'b1, 1'b0, 3'b001, nfx(2'd3)};
        tbl[1]  = '{3'b111, 1'b1, 1'b0, 3'b010, nfx(2'd2)};
        tbl[2]  = '{3'b111, 1'b1, 1'b0, 3'b100, nfx(2'd1)};
        tbl[3]  = '{3'b000, 1'b1, 1'b1, 3'b000, nfx(2'd0)};
        tbl[4]  = '{3'b000, 1'b1, 1'b1, 3'b000, nfx(2'd1)};
        tbl[5]  = '{3'b000, 1'b1, 1'b1, 3'b000, nfx(2'd2)};
        tbl[6]  = '{3'b111, 1'b1, 1'b0, 3'b001, nfx(2'd3)};
        tbl[7]  = '{3'b100, 1'b0, 1'b0, 3'b000, nfx(2'd2)};
        tbl[8]  = '{3'b100, 1'b0, 1'b0, 3'b000, nfx(2'd2)};
        tbl[9]  = '{3'b100, 1'b0, 1'b0, 3'b000, nfx(2'd2)};
        tbl[10] = '{3'b100, 1'b1, 1'b0, 3'b100, nfx(2'd2)};
        tbl[11] = '{3'b111, 1'b1, 1'b0, 3'b001, nfx(2'd1)};
        tbl[12] = '{3'b000, 1'b1, 1'b1, 3'b000, nfx(2'd0)};
        tbl[13] = '{3'b000, 1'b1, 1'b1, 3'b000, nfx(2'd1)};
        tbl[14] = '{3'b000, 1'b1, 1'b1, 3'b000, nfx(2'd2)};
        tbl[15] = '{3'b000, 1'b1, 1'b0, 3'b000, nfx(2'd3)};

        // Reset held low: requests with a ready downstream must still see no grant.
        apply(1'b0, 3'b111, 1'b1, 1'b0);
        chk_all("reset_low", 3'b000, 2'd3, 1'b0);
        apply(1'b0, 3'b111, 1'b1, 1'b1);
        chk_all("reset_low2", 3'b000, 2'd3, 1'b0);

        for (int i = 0; i < 16; i++) begin
            apply(1'b1, tbl[i].reqs, tbl[i].rdy, tbl[i].cr);
            chk_all($sformatf("tbl%0d", i), tbl[i].g, tbl[i].nf, 1'b0);
        end

        // Credit corner cases; prio points at input 1 and credits are full here.
        if (CE) begin
            apply(1'b1, 3'b010, 1'b1, 1'b0); chk_all("exh0", 3'b010, 2'd3, 1'b0);
            apply(1'b1, 3'b010, 1'b1, 1'b0); chk_all("exh1", 3'b010, 2'd2, 1'b0);
            apply(1'b1, 3'b010, 1'b1, 1'b0); chk_all("exh2", 3'b010, 2'd1, 1'b0);
            apply(1'b1, 3'b010, 1'b1, 1'b0); chk_all("exh3", 3'b000, 2'd0, 1'b0);
            apply(1'b1, 3'b010, 1'b1, 1'b1); chk_all("ret0", 3'b000, 2'd0, 1'b0);
            apply(1'b1, 3'b010, 1'b1, 1'b0); chk_all("ret1", 3'b010, 2'd1, 1'b0);
            apply(1'b1, 3'b010, 1'b1, 1'b0); chk_all("ret2", 3'b000, 2'd0, 1'b0);
            apply(1'b1, 3'b000, 1'b1, 1'b1); chk_all("fill0", 3'b000, 2'd0, 1'b0);
            apply(1'b1, 3'b000, 1'b1, 1'b1); chk_all("fill1", 3'b000, 2'd1, 1'b0);
            apply(1'b1, 3'b010, 1'b1, 1'b1); chk_all("simul0", 3'b010, 2'd2, 1'b0);
            apply(1'b1, 3'b000, 1'b1, 1'b1); chk_all("simul1", 3'b000, 2'd2, 1'b0);
            apply(1'b1, 3'b000, 1'b1, 1'b1); chk_all("ovf0", 3'b000, 2'd3, 1'b0);
            apply(1'b1, 3'b000, 1'b1, 1'b0); chk_all("ovf1", 3'b000, 2'd3, 1'b1);
            apply(1'b1, 3'b010, 1'b1, 1'b0); chk_all("ovf2", 3'b010, 2'd3, 1'b1);
            apply(1'b1, 3'b000, 1'b1, 1'b1); chk_all("ovf3", 3'b000, 2'd2, 1'b1);
            apply(1'b1, 3'b000, 1'b1, 1'b0); chk_all("ovf4", 3'b000, 2'd3, 1'b1);
            apply(1'b0, 3'b000, 1'b1, 1'b0); chk_all("ovf_rst", 3'b000, 2'd3, 1'b0);
        end else begin
            for (int i = 0; i < 20; i++) begin
                apply(1'b1, 3'($urandom_range(0, 7)), 1'b1, 1'($urandom_range(0, 1)));
                chk($sformatf("nocred%0d_num_free", i), {30'd0, num_free}, 32'd3);
                chk($sformatf("nocred%0d_credit_err", i), {31'd0, credit_err}, 32'd0);
            end
            apply(1'b0, 3'b000, 1'b1, 1'b0);
        end

        // Mid-operation reset: drop reset between edges while input 2 holds the grant.
        apply(1'b1, 3'b000, 1'b1, 1'b0);
        apply(1'b1, 3'b100, 1'b1, 1'b0);
        chk_all("mid_pre", 3'b100, 2'd3, 1'b0);
        #1 reset = 1'b0;
        #1;
        chk_all("mid_low", 3'b000, 2'd3, 1'b0);
        apply(1'b0, 3'b100, 1'b1, 1'b0);
        chk_all("mid_hold", 3'b000, 2'd3, 1'b0);
        apply(1'b1, 3'b111, 1'b1, 1'b0);
        chk_all("mid_post", 3'b001, 2'd3, 1'b0);

        // Random traffic against a behavioural model of arbitration and credits.
        apply(1'b0, 3'b000, 1'b0, 1'b0);
        m_prio = 0;
        m_credits = NCRED;
        m_err = 1'b0;
        for (int c = 0; c < 400; c++) begin
            rst_s = ($urandom_range(0, 59) != 0);
            r_s   = 3'($urandom_range(0, 7));
            rdy_s = ($urandom_range(0, 3) != 0);
            cr_s  = ($urandom_range(0, 2) == 0);
            if (!rst_s) begin
                m_prio = 0;
                m_credits = NCRED;
                m_err = 1'b0;
            end
            g_idx = -1;
            if (rst_s && rdy_s && (!CE || m_credits > 0)) begin
                for (int k = 0; k < 3; k++) begin
                    idx = (m_prio + k) % 3;
                    if (g_idx < 0 && ((r_s >> idx) & 3'b001) != 3'b000) begin
                        g_idx = idx;
                    end
                end
            end
            exp_g = (g_idx < 0) ? 3'b000 : (3'b001 << g_idx);
            apply(rst_s, r_s, rdy_s, cr_s);
            chk_all($sformatf("rnd%0d", c), exp_g, CE ? 2'(m_credits) : 2'd3, CE ? m_err : 1'b0);
            if (rst_s) begin
                if (g_idx >= 0) begin
                    m_prio = (g_idx + 1) % 3;
                end
                if (CE) begin
                    if (g_idx >= 0 && !cr_s) begin
                        m_credits = m_credits - 1;
                    end else if (cr_s && g_idx < 0) begin
                        if (m_credits == NCRED) begin
                            m_err = 1'b1;
                        end else begin
                            m_credits = m_credits + 1;
                        end
                    end
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
